// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divide/phase strobes and divided clocks.
// Optional readback of stored channel settings is enabled by defining CLK_EN_GEN_READBACK_EN.
module clk_en_gen #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] outen,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
`ifdef CLK_EN_GEN_READBACK_EN
  ,
  output logic [CNT_W-1:0]  rd_div,
  output logic [CNT_W-1:0]  rd_phase
`endif
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_ALIGN, ST_SETTLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              ready_q, ready_d;
  logic [NUM_CH-1:0] outen_q, outen_d, outclk_q, outclk_d;
  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  logic [CNT_W-1:0]  phase_q [NUM_CH];
  logic [CNT_W-1:0]  phase_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  eff_div [NUM_CH];
  logic [CNT_W-1:0]  eff_ph  [NUM_CH];
  logic              cfg_hit;

  assign cfg_hit = (state_q == ST_LOCKED) && cfg_we && (32'(cfg_ch) < NUM_CH);

  // NOTE: every variable written in a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_ALIGN: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(LOCK_CYCLES - 1)) state_d = ST_LOCKED;
        else                                     settle_d = settle_q + SET_W'(1);
      end
      ST_LOCKED: if (cfg_hit) state_d = ST_ALIGN;
      default:   state_d = ST_ALIGN;
    endcase
    ready_d = (state_d == ST_LOCKED);
  end

  // cnt tracks (k - phase) mod div, so the strobe fires at 0 and the clock is high below div/2.
  always_comb begin
    outen_d  = '0;
    outclk_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (cfg_hit && (CH_W'(i) == cfg_ch)) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
      eff_div[i] = (div_q[i] == '0) ? ONE : div_q[i];
      eff_ph[i]  = (phase_q[i] > eff_div[i] - ONE) ? eff_div[i] - ONE : phase_q[i];
      if (state_d == ST_LOCKED) begin
        outen_d[i]  = (cnt_q[i] == '0);
        outclk_d[i] = (cnt_q[i] < (eff_div[i] >> 1));
        cnt_d[i]    = (cnt_q[i] == eff_div[i] - ONE) ? '0 : cnt_q[i] + ONE;
      end else begin
        cnt_d[i]    = (eff_ph[i] == '0) ? '0 : eff_div[i] - eff_ph[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q  <= ST_ALIGN;
      settle_q <= '0;
      ready_q  <= 1'b0;
      outen_q  <= '0;
      outclk_q <= '0;
      // NOTE: the channel settings are small register arrays, not RAM, so they are reset to their defaults.
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= CNT_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ready_q  <= ready_d;
      outen_q  <= outen_d;
      outclk_q <= outclk_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign cfg_ready = ready_q;
  assign locked    = ready_q;
  assign outen     = outen_q;
  assign outclk    = outclk_q;

`ifdef CLK_EN_GEN_READBACK_EN
  logic [CNT_W-1:0] rd_div_q, rd_div_d, rd_phase_q, rd_phase_d;

  always_comb begin
    rd_div_d   = '0;
    rd_phase_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == cfg_ch) begin
        rd_div_d   = div_q[i];
        rd_phase_d = phase_q[i];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      rd_div_q   <= '0;
      rd_phase_q <= '0;
    end else begin
      rd_div_q   <= rd_div_d;
      rd_phase_q <= rd_phase_d;
    end
  end

  assign rd_div   = rd_div_q;
  assign rd_phase = rd_phase_q;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: behavioural model feeds a scoreboard queue, plus table-driven config writes.
module tb_clk_en_gen;

  localparam int NCH = 3;

  logic        refclk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div, cfg_phase;
  logic        cfg_ready, locked;
  logic [2:0]  outen, outclk;
`ifdef CLK_EN_GEN_READBACK_EN
  logic [15:0] rd_div, rd_phase;
`endif

  always #5 refclk = ~refclk;

  clk_en_gen dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_ready (cfg_ready),
    .outen     (outen),
    .outclk    (outclk),
    .locked    (locked)
`ifdef CLK_EN_GEN_READBACK_EN
    ,
    .rd_div    (rd_div),
    .rd_phase  (rd_phase)
`endif
  );

  typedef enum {M_ALIGN, M_SETTLE, M_LOCKED} mstate_e;

  typedef struct {
    logic        lk;
    logic [2:0]  en;
    logic [2:0]  ck;
    logic [15:0] rdd;
    logic [15:0] rdp;
  } exp_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] div;
    logic [15:0] phase;
    logic [7:0]  en_mask;  // bit kk = outen[ch] at k=kk after relock
    logic [7:0]  ck_mask;
  } vec_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  mstate_e     m_state = M_ALIGN;
  int          m_scnt = 0;
  int          k = 0;
  logic [15:0] m_div   [NCH];
  logic [15:0] m_phase [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '{default: '0};
    if (m_state == M_LOCKED) begin
      e.lk = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        int d, p, r;
        d = (m_div[i] == 16'd0) ? 1 : int'(m_div[i]);
        p = (int'(m_phase[i]) > d - 1) ? d - 1 : int'(m_phase[i]);
        r = k % d;
        e.en[i] = (r == p);
        e.ck[i] = (((r - p + d) % d) < (d / 2));
      end
    end
    return e;
  endfunction

  // Advances the model across one edge using the inputs currently driven.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i]   = 16'd2;
        m_phase[i] = 16'd0;
      end
      m_state = M_ALIGN;
    end else begin
      case (m_state)
        M_ALIGN: begin
          m_state = M_SETTLE;
          m_scnt  = 1;
        end
        M_SETTLE: begin
          if (m_scnt == 16) begin
            m_state = M_LOCKED;
            k       = 0;
          end else m_scnt++;
        end
        default: begin
          if (cfg_we && int'(cfg_ch) < NCH) begin
            m_div[cfg_ch]   = cfg_div;
            m_phase[cfg_ch] = cfg_phase;
            m_state         = M_ALIGN;
          end else k++;
        end
      endcase
    end
  endtask

  task automatic tick(input string tag);
    exp_t e, m;
    logic [15:0] rdd, rdp;
    rdd = '0;
    rdp = '0;
    if (rst_n && int'(cfg_ch) < NCH) begin
      rdd = m_div[cfg_ch];
      rdp = m_phase[cfg_ch];
    end
    model_edge();
    m     = model_out();
    m.rdd = rdd;
    m.rdp = rdp;
    sb_q.push_back(m);
    @(posedge refclk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("%s.locked", tag),    32'(locked),    32'(e.lk));
    check($sformatf("%s.cfg_ready", tag), 32'(cfg_ready), 32'(e.lk));
    check($sformatf("%s.outen", tag),     32'(outen),     32'(e.en));
    check($sformatf("%s.outclk", tag),    32'(outclk),    32'(e.ck));
`ifdef CLK_EN_GEN_READBACK_EN
    check($sformatf("%s.rd_div", tag),    32'(rd_div),    32'(e.rdd));
    check($sformatf("%s.rd_phase", tag),  32'(rd_phase),  32'(e.rdp));
`endif
  endtask

  // Returns the number of edges taken for locked to rise (bounded).
  task automatic wait_lock(input string tag, output int n);
    n = 0;
    do begin
      tick(tag);
      n++;
    end while (locked !== 1'b1 && n < 40);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    vec_t vecs[4];
    int   n;

    vecs[0] = '{ch: 2'd1, div: 16'd5, phase: 16'd2, en_mask: 8'h84, ck_mask: 8'h8C};
    vecs[1] = '{ch: 2'd0, div: 16'd4, phase: 16'd9, en_mask: 8'h88, ck_mask: 8'h99};
    vecs[2] = '{ch: 2'd2, div: 16'd0, phase: 16'd0, en_mask: 8'hFF, ck_mask: 8'h00};
    vecs[3] = '{ch: 2'd2, div: 16'd1, phase: 16'd0, en_mask: 8'hFF, ck_mask: 8'h00};

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd0;
    cfg_phase = 16'd0;

    tick("reset");
    check("reset_outen", 32'(outen), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    wait_lock("powerup", n);
    check("powerup_lock_edges", 32'(n), 32'd17);
    check("dflt_en_k0", 32'(outen), 32'h7);
    check("dflt_clk_k0", 32'(outclk), 32'h7);
    tick("dflt");
    check("dflt_en_k1", 32'(outen), 32'h0);
    check("dflt_clk_k1", 32'(outclk), 32'h0);
    run("dflt", 6);

    for (int v = 0; v < 4; v++) begin
      cfg_we    = 1'b1;
      cfg_ch    = vecs[v].ch;
      cfg_div   = vecs[v].div;
      cfg_phase = vecs[v].phase;
      tick($sformatf("wr%0d", v));
      check($sformatf("wr%0d_locked_falls", v), 32'(locked), 32'd0);
      cfg_we = 1'b0;
      wait_lock($sformatf("wr%0d_settle", v), n);
      check($sformatf("wr%0d_lock_edges", v), 32'(n), 32'd17);
      for (int kk = 0; kk < 8; kk++) begin
        check($sformatf("wr%0d_en_k%0d", v, kk), 32'(outen[vecs[v].ch]), 32'(vecs[v].en_mask[kk]));
        check($sformatf("wr%0d_clk_k%0d", v, kk), 32'(outclk[vecs[v].ch]), 32'(vecs[v].ck_mask[kk]));
        tick($sformatf("wr%0d_run", v));
      end
      run($sformatf("wr%0d_tail", v), 6);
    end

    // A write pulsed during SETTLE must neither store nor shift the lock point.
    cfg_we    = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 16'd3;
    cfg_phase = 16'd1;
    tick("settle_wr");
    cfg_we = 1'b0;
    run("settle_pre", 4);
    cfg_we    = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd7;
    cfg_phase = 16'd0;
    tick("settle_we");
    cfg_we = 1'b0;
    wait_lock("settle_post", n);
    check("settle_lock_edges", 32'(n + 5), 32'd17);
    run("settle_run", 12);

    // Out-of-range channel: no relock, patterns continue.
    cfg_we    = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 16'd7;
    cfg_phase = 16'd1;
    tick("bad_ch");
    check("bad_ch_locked", 32'(locked), 32'd1);
    cfg_we = 1'b0;
    run("bad_ch_run", 10);

    // Reset while LOCKED with ch1 at div=5 restores defaults.
    cfg_ch = 2'd1;
    rst_n  = 1'b0;
    tick("mid_rst");
    check("mid_rst_outen", 32'(outen), 32'd0);
    check("mid_rst_outclk", 32'(outclk), 32'd0);
    rst_n = 1'b1;
    wait_lock("mid_rst_relock", n);
    check("mid_rst_lock_edges", 32'(n), 32'd17);
    check("mid_rst_ch1_en_k0", 32'(outen[1]), 32'd1);
    tick("mid_rst_run");
    check("mid_rst_ch1_en_k1", 32'(outen[1]), 32'd0);
    run("mid_rst_run", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised multi-channel clock-enable generator and the fabric-side successor to the fixed 3-output PLL wrapper.
- Derives NUM_CH divided strobes (outen) and 50%-style divided clocks (outclk) from refclk.
- Divide ratio and phase offset are runtime-programmable per channel.
- After every (re)configuration, all channels are re-aligned to a common origin and a settle interval elapses before locked asserts.
- Sits between the system clock source and slow peripherals that need phase-related enables.

Parameters:
- NUM_CH, 3: number of output channels (1..16).
- CNT_W, 16: width of the divide and phase registers and counters.
- LOCK_CYCLES, 16: settle cycles between alignment and lock (>=1).
- DEF_DIV, 2: divide ratio loaded into every channel at reset (>=1).

Ports:
- refclk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_we  in  1  configuration write strobe; sampled only while cfg_ready=1.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel index.
- cfg_div  in  CNT_W  divide ratio; 0 is treated as 1.
- cfg_phase  in  CNT_W  phase offset in refclk cycles.
- cfg_ready  out  1  block accepts a cfg write.
- outen  out  NUM_CH  one-cycle enable strobe per channel.
- outclk  out  NUM_CH  divided clock level per channel.
- locked  out  1  all channels aligned and settled.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge):
  - div[i]=DEF_DIV, phase[i]=0.
  - FSM goes to ALIGN.
  - outen=0, outclk=0, locked=0, cfg_ready=0.
- FSM states:
  - ALIGN: lasts 1 cycle; all channel counters are cleared; then goes to SETTLE.
  - SETTLE: lasts exactly LOCK_CYCLES cycles, counted by a settle counter; then goes to LOCKED.
  - LOCKED: locked=1, cfg_ready=1.
- Outputs are forced to 0 in ALIGN and SETTLE.
- Lock timing: locked rises on the (1+LOCK_CYCLES)th rising edge after the edge that entered ALIGN. With defaults, that is the 17th edge after reset release.
- Output timing: let k=0 be the first cycle with locked=1 and k increment each cycle. For channel i, with d=max(div[i],1) and p=min(phase[i],d-1), the clamp being silent:
  - outen[i]=1 exactly in cycles where k mod d == p.
  - outclk[i]=1 exactly in cycles where (k-p) mod d < floor(d/2).
- d=1: outen[i] is constantly 1 and outclk[i] is constantly 0.
- Odd d: outclk high for floor(d/2) cycles, low for the remainder.
- Counters wrap at d-1 to 0 with no skipped or repeated state.
- Channels with the same d and p are cycle-identical.
- Config write (cfg_we=1 and cfg_ready=1 at edge E):
  - div/phase of cfg_ch update at E.
  - FSM enters ALIGN at E.
  - locked, cfg_ready, outen and outclk are 0 from E.
  - All channels, including unmodified ones, re-align.
- cfg_we while cfg_ready=0: ignored, with no effect.
- cfg_ch >= NUM_CH: write ignored; no relock; locked stays 1.
- Reset mid-operation (any state): the reset behaviour above applies on that edge; programmed values are lost.
- No combinational path from any input to any output.

Optional Feature:
- Macro CLK_EN_GEN_READBACK_EN.
- Defined:
  - Adds outputs rd_div[CNT_W] and rd_phase[CNT_W].
  - On each edge they register the stored div/phase of cfg_ch, giving 1-cycle latency.
  - rd_phase returns the stored, unclamped value.
  - cfg_ch >= NUM_CH returns 0.
  - Both read 0 during reset.
- Undefined: the ports do not exist and no readback muxing is synthesised.

Test Plan:
- Defaults, release rst_n: locked=0 for 16 edges, 1 at the 17th. Then:
  - outen=3'b111 at k=0,2,4…, 3'b000 at k odd.
  - outclk=3'b111 at k even, 3'b000 at k odd.
- After lock, write ch1 div=5 phase=2 at edge E:
  - locked and cfg_ready fall at E; locked rises at E+17.
  - outen[1]=1 at k=2,7,12; outclk[1]=1 at k=2,3, 0 at k=4,5,6.
  - ch0 and ch2 restart at k=0.
- Write ch0 div=4 phase=9: phase clamps to 3; outen[0]=1 at k=3,7,11; outclk[0]=1 at k=3,4.
- Write ch2 div=0 and, separately, div=1: after lock, outen[2]=1 and outclk[2]=0 every cycle.
- These writes must be ignored:
  - cfg_we pulsed during SETTLE: stored values unchanged and lock timing unchanged.
  - cfg_ch=3 with NUM_CH=3: locked stays 1 and the patterns continue unbroken.
- rst_n=0 for one edge while LOCKED with ch1 div=5:
  - All outputs 0 at that edge.
  - After relock, ch1 behaves as div=2 phase=0.
  - With CLK_EN_GEN_READBACK_EN, rd_div=2 for cfg_ch=1.
